// File: rtl/ped_request_in.sv
// ped_request_in
//
// Pedestrian push-button front end for the traffic-light sequencer.
// The raw active-low button is synchronised into sys_clk and debounced.
// Each debounced press raises a pedestrian request. The request is held
// until the sequencer acknowledges it. A hold-off window then discards
// further presses, so pedestrians cannot starve vehicle traffic.
//
// Optional feature macro: PED_LONGPRESS_EN
//   Defined   : ped_long pulses once per press after LONGPRESS_CYCLES of hold.
//   Undefined : ped_long is tied to 0 and the press-duration counter is absent.
//
// Ports
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset
//   btn_n      in   raw button, low = pressed, asynchronous to sys_clk
//   req_ack    in   sequencer acknowledge, level-sampled
//   ped_req    out  pending pedestrian request, held until acknowledged
//   btn_level  out  debounced button state, 1 = pressed
//   btn_press  out  one-cycle pulse on the debounced press edge
//   ped_long   out  one-cycle long-press pulse
module ped_request_in #(
    parameter int DEBOUNCE_CYCLES  = 640_000,
    parameter int HOLDOFF_CYCLES   = 32_000_000,
    parameter int LONGPRESS_CYCLES = 96_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic btn_n,
    input  logic req_ack,
    output logic ped_req,
    output logic btn_level,
    output logic btn_press,
    output logic ped_long
);

    // Counters are at least 1 bit wide so a parameter of 1 still elaborates.
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HO_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchroniser; the inversion happens on the way in so both
    // flops reset to "released".
    // ------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= ~btn_n;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: the counter only advances while the synchronised input
    // disagrees with the accepted level, and any agreement restarts it.
    // ------------------------------------------------------------------
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            level_q;
    logic            level_d;
    logic            press_q;
    logic            press_d;

    always_comb begin
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        press_d  = 1'b0;
        if (sync2_q == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            level_d  = ~level_q;
            db_cnt_d = '0;
            // Only the released-to-pressed transition produces a pulse.
            press_d  = ~level_q;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            db_cnt_q <= '0;
            level_q  <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
            press_q  <= press_d;
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;

    // ------------------------------------------------------------------
    // Request FSM. The case arms are evaluated against the current state,
    // so an ack in PENDING beats a coincident press, and a press in the
    // final HOLDOFF cycle is dropped.
    // ------------------------------------------------------------------
    state_t          state_q;
    logic [HO_W-1:0] hold_cnt_q;
    logic            req_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            req_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (press_q) begin
                        state_q <= ST_PENDING;
                        req_q   <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    // Extra presses are absorbed; there is no queue.
                    if (req_ack) begin
                        state_q    <= ST_HOLDOFF;
                        hold_cnt_q <= '0;
                        req_q      <= 1'b0;
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_cnt_q == HO_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ped_req = req_q;

    // ------------------------------------------------------------------
    // Long-press detector
    // ------------------------------------------------------------------
`ifdef PED_LONGPRESS_EN
    localparam int LP_W = (LONGPRESS_CYCLES > 1) ? $clog2(LONGPRESS_CYCLES) : 1;
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONGPRESS_CYCLES - 1);
    // The pulse is registered, so it is armed one count early and appears
    // in the same cycle the counter shows LONGPRESS_CYCLES-1.
    localparam logic [LP_W-1:0] LP_ARM  = LP_W'(LONGPRESS_CYCLES - 2);

    logic [LP_W-1:0] lp_cnt_q;
    logic            long_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lp_cnt_q <= '0;
            long_q   <= 1'b0;
        end else if (!level_q) begin
            lp_cnt_q <= '0;
            long_q   <= 1'b0;
        end else begin
            long_q <= (lp_cnt_q == LP_ARM);
            // Saturate at the terminal count: one pulse per press.
            if (lp_cnt_q != LP_LAST) begin
                lp_cnt_q <= lp_cnt_q + 1'b1;
            end
        end
    end

    assign ped_long = long_q;
`else
    assign ped_long = 1'b0;
`endif

endmodule
